clock_controller: RTL and testbench

- Synchronous, parametrised board clock controller for the MIPS CPU on the FPGA.
- Generates a slow CPU clock from the board clock using a programmable divider.
- Supports three modes: free-run with start/pause, single-step, and N-cycle burst.
- Debounces both pushbuttons internally. Stops only on cycle boundaries, so the CPU never sees a truncated high phase.

---
 rtl/clock_controller_pkg.sv | 25 ++
 rtl/button_debounce.sv | 43 ++++
 rtl/clock_controller.sv | 142 ++++++++++++++
 tb/tb_clock_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_controller_pkg.sv
// Shared encodings and helpers for the board clock controller.
package clock_controller_pkg;

  localparam int unsigned MODE_W        = 2;
  localparam int unsigned CYCLE_COUNT_W = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COUNTED = 2'd2
  } state_e;

  // The reserved encoding behaves as free-run.
  function automatic logic is_run_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_RUN) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low pushbutton debouncer: 2-FF synchroniser, stability counter,
// one-cycle press pulse on an accepted 1->0 transition.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        press <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_controller.sv
// Slow CPU clock generator with free-run, single-step and burst modes;
// stops only on cycle boundaries so clk_out never has a truncated high phase.
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned STEP_WIDTH      = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     start_button,
  input  logic                     step_button,
  input  logic [MODE_W-1:0]        mode,
  input  logic [DIV_WIDTH-1:0]     div_value,
  input  logic [STEP_WIDTH-1:0]    burst_count,
  output logic                     clk_out,
  output logic                     cpu_tick,
  output logic                     running,
  output logic [CYCLE_COUNT_W-1:0] cycle_count
);

  logic start_level, start_press;
  logic step_level, step_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk_in (clk_in),
    .reset  (reset),
    .btn_n  (start_button),
    .level  (start_level),
    .press  (start_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_in (clk_in),
    .reset  (reset),
    .btn_n  (step_button),
    .level  (step_level),
    .press  (step_press)
  );

  state_e                   state, state_next;
  logic [DIV_WIDTH-1:0]     divider, divider_next;
  logic [STEP_WIDTH-1:0]    remaining, remaining_next;
  logic                     stop_pending, stop_pending_next;
  logic                     clk_out_next, cpu_tick_next;
  logic [CYCLE_COUNT_W-1:0] cycle_count_next;

  logic start_ev, step_ev, tick, rise, fall, stop_now;

  // A press pulse always coincides with the held (low) debounced level.
  assign start_ev = start_press & ~start_level;
  assign step_ev  = step_press & ~step_level;

  assign tick     = (state != ST_IDLE) && (divider >= div_value);
  assign rise     = tick & ~clk_out;
  assign fall     = tick & clk_out;
  assign stop_now = (stop_pending | start_ev) & (fall | (~clk_out & (divider == '0)));

  always_ff @(posedge clk_in) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (is_run_mode(mode)) begin
          if (start_ev) state_next = ST_RUN;
        end else if (mode == MODE_STEP) begin
          if (step_ev) state_next = ST_COUNTED;
        end else if (start_ev && (burst_count != '0)) begin
          state_next = ST_COUNTED;
        end
      end
      ST_RUN:     if (stop_now) state_next = ST_IDLE;
      ST_COUNTED: if (fall && (remaining == STEP_WIDTH'(1))) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Divider, phase and counters: held cleared in IDLE, restarted on entry.
  always_comb begin
    divider_next      = divider;
    clk_out_next      = clk_out;
    cpu_tick_next     = 1'b0;
    cycle_count_next  = cycle_count;
    remaining_next    = remaining;
    stop_pending_next = stop_pending;
    if (state_next == ST_IDLE) begin
      divider_next      = '0;
      clk_out_next      = 1'b0;
      remaining_next    = '0;
      stop_pending_next = 1'b0;
    end else if (state == ST_IDLE) begin
      divider_next      = '0;
      clk_out_next      = 1'b0;
      stop_pending_next = 1'b0;
      if (state_next == ST_COUNTED)
        remaining_next = (mode == MODE_STEP) ? STEP_WIDTH'(1) : burst_count;
      else
        remaining_next = '0;
    end else begin
      if (tick) begin
        divider_next = '0;
        clk_out_next = ~clk_out;
      end else begin
        divider_next = divider + DIV_WIDTH'(1);
      end
      if (rise) begin
        cpu_tick_next    = 1'b1;
        cycle_count_next = cycle_count + CYCLE_COUNT_W'(1);
      end
      if (fall && (state == ST_COUNTED))
        remaining_next = remaining - STEP_WIDTH'(1);
      if ((state == ST_RUN) && start_ev)
        stop_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      divider      <= '0;
      clk_out      <= 1'b0;
      cpu_tick     <= 1'b0;
      running      <= 1'b0;
      cycle_count  <= '0;
      remaining    <= '0;
      stop_pending <= 1'b0;
    end else begin
      divider      <= divider_next;
      clk_out      <= clk_out_next;
      cpu_tick     <= cpu_tick_next;
      running      <= (state_next != ST_IDLE);
      cycle_count  <= cycle_count_next;
      remaining    <= remaining_next;
      stop_pending <= stop_pending_next;
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller: scenario table plus hand-written
// corner sequences, with a tick scoreboard checked on every cpu_tick.
module tb_clock_controller;

  localparam int unsigned DIV_W  = 26;
  localparam int unsigned STEP_W = 8;
  localparam int          DIV    = 2;
  localparam int          PERIOD = 2 * (DIV + 1);

  logic              clk_in = 1'b0;
  logic              reset;
  logic              start_button, step_button;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div_value;
  logic [STEP_W-1:0] burst_count;
  logic              clk_out, cpu_tick, running;
  logic [31:0]       cycle_count;

  clock_controller #(
    .DIV_WIDTH(DIV_W), .DEBOUNCE_CYCLES(4), .STEP_WIDTH(STEP_W)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .start_button (start_button),
    .step_button  (step_button),
    .mode         (mode),
    .div_value    (div_value),
    .burst_count  (burst_count),
    .clk_out      (clk_out),
    .cpu_tick     (cpu_tick),
    .running      (running),
    .cycle_count  (cycle_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int count; bit first; } tick_t;
  typedef struct {
    logic [1:0]        mode;
    logic [STEP_W-1:0] burst;
    bit                use_step;
    bit                mid_change;
    int                ticks;
  } vec_t;

  tick_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc = 0;
  int    run_start = 0;
  int    last_tick = 0;
  bit    prev_running = 1'b0;
  int    exp_count = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic press(input bit use_step, input int n);
    if (use_step) step_button = 1'b0;
    else          start_button = 1'b0;
    step_cycles(n);
    start_button = 1'b1;
    step_button  = 1'b1;
  endtask

  task automatic push_ticks(input int from, input int n);
    for (int k = 0; k < n; k++) sb.push_back('{count: from + k + 1, first: (k == 0)});
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard: every rising CPU edge must match the next expected tick.
  always @(negedge clk_in) begin
    tick_t e;
    if (running && !prev_running) run_start = cyc;
    prev_running = running;
    if (!reset && cpu_tick) begin
      if (sb.size() == 0) begin
        check("tick_unexpected", 32'(cpu_tick), 0);
      end else begin
        e = sb.pop_front();
        check("tick_count", cycle_count, e.count);
        check("tick_clk_high", 32'(clk_out), 1);
        if (e.first) check("tick_latency", cyc - run_start, DIV + 1);
        else         check("tick_period", cyc - last_tick, PERIOD);
        last_tick = cyc;
      end
    end
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b01, 8'd0, 1'b1, 1'b0, 1};  // step
    vecs[1] = '{2'b01, 8'd0, 1'b1, 1'b0, 1};  // step
    vecs[2] = '{2'b01, 8'd0, 1'b1, 1'b0, 1};  // step
    vecs[3] = '{2'b01, 8'd0, 1'b0, 1'b0, 0};  // start ignored in STEP
    vecs[4] = '{2'b10, 8'd5, 1'b0, 1'b0, 5};  // burst of 5
    vecs[5] = '{2'b10, 8'd5, 1'b0, 1'b1, 5};  // mode change mid-burst ignored
    vecs[6] = '{2'b10, 8'd0, 1'b0, 1'b0, 0};  // empty burst stays idle
    vecs[7] = '{2'b10, 8'd3, 1'b1, 1'b0, 0};  // step ignored in BURST
    vecs[8] = '{2'b00, 8'd0, 1'b1, 1'b0, 0};  // step ignored in RUN

    reset = 1'b1; start_button = 1'b1; step_button = 1'b1;
    mode = 2'b00; div_value = DIV_W'(DIV); burst_count = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); #1;
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_running", 32'(running), 0);
    check("reset_count", cycle_count, 0);
    check("reset_tick", 32'(cpu_tick), 0);
    reset = 1'b0;
    step_cycles(2);

    // Short glitch must not produce an event.
    press(1'b0, 3);
    step_cycles(15);
    check("glitch_running", 32'(running), 0);

    // Free-run, then stop requested during the high phase of cycle 4.
    push_ticks(0, 4);
    press(1'b0, 10);
    check("run_started", 32'(running), 1);
    for (int i = 0; i < 100; i++) begin
      step_cycles(1);
      if (cpu_tick && cycle_count == 3) break;
    end
    check("run_tick3_seen", cycle_count, 3);
    step_cycles(1);
    start_button = 1'b0;
    step_cycles(7);
    check("stop_clk_still_high", 32'(clk_out), 1);
    check("stop_still_running", 32'(running), 1);
    step_cycles(1);
    check("stop_clk_low", 32'(clk_out), 0);
    check("stop_idle", 32'(running), 0);
    check("stop_count", cycle_count, 4);
    step_cycles(2);
    start_button = 1'b1;
    step_cycles(20);
    check("stop_sb_empty", sb.size(), 0);
    check("stop_stays_idle", 32'(running), 0);
    exp_count = 4;

    foreach (vecs[v]) begin
      mode = vecs[v].mode;
      burst_count = vecs[v].burst;
      push_ticks(exp_count, vecs[v].ticks);
      exp_count += vecs[v].ticks;
      press(vecs[v].use_step, 10);
      for (int i = 0; i < vecs[v].ticks * PERIOD + 20; i++) begin
        if (vecs[v].mid_change && i == 3) begin
          mode = 2'b00;
          burst_count = 8'd9;
        end
        step_cycles(1);
      end
      check($sformatf("vec%0d_running", v), 32'(running), 0);
      check($sformatf("vec%0d_clk_out", v), 32'(clk_out), 0);
      check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
      check($sformatf("vec%0d_count", v), cycle_count, exp_count);
    end

    // Reset in the middle of a burst while clk_out is high.
    mode = 2'b10; burst_count = 8'd5;
    push_ticks(exp_count, 2);
    press(1'b0, 10);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && cpu_tick) break;
      step_cycles(1);
    end
    check("midburst_clk_high", 32'(clk_out), 1);
    reset = 1'b1;
    step_cycles(1);
    check("midreset_clk_out", 32'(clk_out), 0);
    check("midreset_running", 32'(running), 0);
    check("midreset_count", cycle_count, 0);
    check("midreset_tick", 32'(cpu_tick), 0);
    step_cycles(1);
    reset = 1'b0;
    mode = 2'b00;
    step_cycles(2);

    // RUN after reset behaves as from power-up.
    push_ticks(0, 2);
    press(1'b0, 10);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      step_cycles(1);
    end
    check("post_reset_count", cycle_count, 2);
    check("post_reset_running", 32'(running), 1);
    reset = 1'b1;
    step_cycles(2);
    reset = 1'b0;
    step_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
